// File: rtl/rr_req_shaper.sv
// rr_req_shaper: requester-side front end for a round-robin arbiter.
// Buffers per-sender entries in small FIFOs, drives req from occupancy,
// forwards the granted head entry one cycle after a valid grant, and
// keeps sticky error flags on arbiter misbehaviour.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push_valid/data   per-sender entry offer (data at [i*DW +: DW])
//   push_ready        per-sender FIFO has room
//   req / gnt         request vector out, grant vector in (comb from req)
//   out_valid/id/data granted entry, registered
//   err_onehot        sticky: gnt had more than one bit set
//   err_spur          sticky: grant bit without matching request
//   err_starve        sticky: a request waited N cycles without grant
//   starve_id         first sender that tripped err_starve
module rr_req_shaper #(
    parameter int N     = 10,
    parameter int DEPTH = 4,
    parameter int DW    = 8,
    parameter int IDW   = (N > 1) ? $clog2(N) : 1,
    parameter int CW    = $clog2(DEPTH + 1),
    parameter int WW    = $clog2(N) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    push_valid,
    input  logic [N*DW-1:0] push_data,
    output logic [N-1:0]    push_ready,
    output logic [N-1:0]    req,
    input  logic [N-1:0]    gnt,
    output logic            out_valid,
    output logic [IDW-1:0]  out_id,
    output logic [DW-1:0]   out_data,
    output logic            err_onehot,
    output logic            err_spur,
    output logic            err_starve,
    output logic [IDW-1:0]  starve_id
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem    [N][DEPTH];
    logic [PW-1:0] rd_ptr [N];
    logic [PW-1:0] wr_ptr [N];
    logic [CW-1:0] cnt    [N];
    logic [WW-1:0] wait_cnt [N];

    logic [N-1:0]   push;
    logic [N-1:0]   pop;
    logic [N-1:0]   gv;
    logic [N-1:0]   trip;
    logic           gv_one;
    logic           multi;
    logic           spur;
    logic [IDW-1:0] gnt_idx;
    logic [DW-1:0]  head;
    logic [IDW-1:0] starve_idx;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        // Pointers wrap at DEPTH, which need not be a power of two.
        if (p == PW'(DEPTH - 1))
            return '0;
        return p + PW'(1);
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) begin
            push_ready[i] = (cnt[i] < CW'(DEPTH));
            req[i]        = (cnt[i] != '0);
        end
    end

    // Spurious bits are masked off; a lone remaining valid bit is still
    // honoured. Raw multi-bit grants only raise the error flag.
    always_comb begin
        gv     = gnt & req;
        spur   = |(gnt & ~req);
        multi  = (gnt & (gnt - N'(1))) != '0;
        gv_one = (gv != '0) && ((gv & (gv - N'(1))) == '0);
        push   = push_valid & push_ready;
        pop    = gv_one ? gv : '0;
    end

    always_comb begin
        gnt_idx = '0;
        head    = '0;
        for (int i = 0; i < N; i++) begin
            if (pop[i]) begin
                gnt_idx = IDW'(i);
                head    = mem[i][rd_ptr[i]];
            end
        end
    end

    // Descending scan so the lowest tripping index wins.
    always_comb begin
        starve_idx = '0;
        for (int i = 0; i < N; i++) begin
            trip[i] = req[i] && !gnt[i]
                   && (wait_cnt[i] == WW'(N - 1));
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (trip[i])
                starve_idx = IDW'(i);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (push[i])
                mem[i][wr_ptr[i]] <= push_data[i*DW +: DW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                rd_ptr[i]   <= '0;
                wr_ptr[i]   <= '0;
                cnt[i]      <= '0;
                wait_cnt[i] <= '0;
            end
            out_valid  <= 1'b0;
            out_id     <= '0;
            out_data   <= '0;
            err_onehot <= 1'b0;
            err_spur   <= 1'b0;
            err_starve <= 1'b0;
            starve_id  <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (push[i])
                    wr_ptr[i] <= ptr_inc(wr_ptr[i]);
                if (pop[i])
                    rd_ptr[i] <= ptr_inc(rd_ptr[i]);
                cnt[i] <= cnt[i] + CW'(push[i]) - CW'(pop[i]);
                if (!req[i] || gnt[i])
                    wait_cnt[i] <= '0;
                else if (wait_cnt[i] != WW'(N))
                    wait_cnt[i] <= wait_cnt[i] + WW'(1);
            end
            out_valid <= gv_one;
            if (gv_one) begin
                out_id   <= gnt_idx;
                out_data <= head;
            end
            if (multi)
                err_onehot <= 1'b1;
            if (spur)
                err_spur <= 1'b1;
            if (|trip) begin
                err_starve <= 1'b1;
                if (!err_starve)
                    starve_id <= starve_idx;
            end
        end
    end

endmodule

// File: tb/tb_rr_req_shaper.sv
// tb_rr_req_shaper: directed bench for rr_req_shaper (N=4, DEPTH=2, DW=8).
// Grants come from a forced vector or a small round-robin arbiter model.
module tb_rr_req_shaper;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    push_valid;
    logic [N*DW-1:0] push_data;
    logic [N-1:0]    push_ready;
    logic [N-1:0]    req;
    logic [N-1:0]    gnt;
    logic            out_valid;
    logic [1:0]      out_id;
    logic [DW-1:0]   out_data;
    logic            err_onehot;
    logic            err_spur;
    logic            err_starve;
    logic [1:0]      starve_id;

    logic [N-1:0] gnt_force;
    logic [N-1:0] arb_gnt;
    logic         arb_en;
    logic [1:0]   ptr;

    int checks   = 0;
    int failures = 0;

    rr_req_shaper #(.N(N), .DEPTH(2), .DW(DW)) dut (
        .clk(clk),
        .rst(rst),
        .push_valid(push_valid),
        .push_data(push_data),
        .push_ready(push_ready),
        .req(req),
        .gnt(gnt),
        .out_valid(out_valid),
        .out_id(out_id),
        .out_data(out_data),
        .err_onehot(err_onehot),
        .err_spur(err_spur),
        .err_starve(err_starve),
        .starve_id(starve_id)
    );

    always #5 clk = ~clk;

    // Round-robin arbiter model: priority starts after the last grant.
    always_comb begin
        arb_gnt = '0;
        for (int k = 1; k <= N; k++) begin
            if (arb_gnt == '0 && req[(32'(ptr) + k) % N])
                arb_gnt[(32'(ptr) + k) % N] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (arb_en && arb_gnt != '0) begin
            for (int k = 0; k < N; k++)
                if (arb_gnt[k])
                    ptr <= 2'(k);
        end
    end

    assign gnt = arb_en ? arb_gnt : gnt_force;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst        = 1'b1;
        push_valid = '0;
        push_data  = '0;
        gnt_force  = '0;
        arb_en     = 1'b0;
        tick();
        tick();
        chk("rst_req", 32'(req), 32'h0);
        chk("rst_ready", 32'(push_ready), 32'hF);
        chk("rst_oval", 32'(out_valid), 32'h0);
        chk("rst_oid", 32'(out_id), 32'h0);
        chk("rst_odata", 32'(out_data), 32'h0);
        chk("rst_errs", {29'd0, err_onehot, err_spur, err_starve}, 32'h0);
        chk("rst_sid", 32'(starve_id), 32'h0);
        rst = 1'b0;

        // 1: single entry on sender 2, granted next cycle
        push_valid = 4'b0100;
        push_data[23:16] = 8'hA1;
        tick();
        push_valid = '0;
        chk("t1_req_t1", 32'(req), 32'h4);
        gnt_force = 4'b0100;
        tick();
        gnt_force = '0;
        chk("t1_oval", 32'(out_valid), 32'h1);
        chk("t1_oid", 32'(out_id), 32'h2);
        chk("t1_odata", 32'(out_data), 32'hA1);
        chk("t1_req_t2", 32'(req), 32'h0);
        tick();
        chk("t1_oval_off", 32'(out_valid), 32'h0);
        chk("t1_oid_hold", 32'(out_id), 32'h2);
        chk("t1_odata_hold", 32'(out_data), 32'hA1);

        // 2: fill sender 0, overflow push waits for a pop
        push_valid = 4'b0001;
        push_data[7:0] = 8'h11;
        tick();
        chk("t2_req_one", 32'(req), 32'h1);
        push_data[7:0] = 8'h22;
        tick();
        chk("t2_full", 32'(push_ready), 32'hE);
        push_data[7:0] = 8'h33;
        tick();
        chk("t2_still_full", 32'(push_ready), 32'hE);
        gnt_force = 4'b0001;
        tick();
        chk("t2_out1", 32'(out_data), 32'h11);
        chk("t2_ready_after_pop", 32'(push_ready), 32'hF);
        tick();
        push_valid = '0;
        chk("t2_out2", 32'(out_data), 32'h22);
        chk("t2_req_pushpop", 32'(req), 32'h1);
        tick();
        gnt_force = '0;
        chk("t2_out3", 32'(out_data), 32'h33);
        chk("t2_oval3", 32'(out_valid), 32'h1);
        chk("t2_req_empty", 32'(req), 32'h0);

        // 3: all senders pending, arbiter model rotates 1,2,3,0
        push_valid = 4'b1111;
        push_data  = 32'h33323130;
        tick();
        push_valid = '0;
        chk("t3_req_all", 32'(req), 32'hF);
        arb_en = 1'b1;
        tick();
        chk("t3_id_a", {24'd0, 6'(out_id), 2'd0} | 32'(out_data) << 8,
            {16'd0, 8'h31, 8'h04});
        tick();
        chk("t3_id_b", {24'd0, 6'(out_id), 2'd0} | 32'(out_data) << 8,
            {16'd0, 8'h32, 8'h08});
        tick();
        chk("t3_id_c", {24'd0, 6'(out_id), 2'd0} | 32'(out_data) << 8,
            {16'd0, 8'h33, 8'h0C});
        tick();
        chk("t3_id_d", {24'd0, 6'(out_id), 2'd0} | 32'(out_data) << 8,
            {16'd0, 8'h30, 8'h00});
        arb_en = 1'b0;
        chk("t3_req_empty", 32'(req), 32'h0);
        chk("t3_errs", {29'd0, err_onehot, err_spur, err_starve}, 32'h0);

        // 4: multi-bit grant pops nothing
        push_valid = 4'b0011;
        push_data[15:0] = 16'h5141;
        tick();
        push_valid = '0;
        gnt_force = 4'b0011;
        tick();
        gnt_force = '0;
        chk("t4_onehot", 32'(err_onehot), 32'h1);
        chk("t4_oval", 32'(out_valid), 32'h0);
        chk("t4_odata_hold", 32'(out_data), 32'h30);
        chk("t4_req_kept", 32'(req), 32'h3);
        chk("t4_ready", 32'(push_ready), 32'hF);
        gnt_force = 4'b0001;
        tick();
        chk("t4_drain0", 32'(out_data), 32'h41);
        gnt_force = 4'b0010;
        tick();
        gnt_force = '0;
        chk("t4_drain1", 32'(out_data), 32'h51);
        chk("t4_drain1_id", 32'(out_id), 32'h1);
        chk("t4_spur_clear", {30'd0, err_spur, err_starve}, 32'h0);

        // 5: spurious grant, then starvation of sender 0
        push_valid = 4'b0001;
        push_data[7:0] = 8'h61;
        tick();
        push_valid = '0;
        gnt_force = 4'b1000;
        tick();
        gnt_force = '0;
        chk("t5_spur", 32'(err_spur), 32'h1);
        chk("t5_oval", 32'(out_valid), 32'h0);
        chk("t5_req", 32'(req), 32'h1);
        tick();
        tick();
        chk("t5_no_starve_yet", 32'(err_starve), 32'h0);
        tick();
        chk("t5_starve", 32'(err_starve), 32'h1);
        chk("t5_sid", 32'(starve_id), 32'h0);

        // 6: reset with entries pending drops everything
        push_valid = 4'b1111;
        push_data  = 32'h77665544;
        tick();
        tick();
        push_valid = '0;
        chk("t6_full", 32'(push_ready), 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_req", 32'(req), 32'h0);
        chk("t6_ready", 32'(push_ready), 32'hF);
        chk("t6_oval", 32'(out_valid), 32'h0);
        chk("t6_errs", {29'd0, err_onehot, err_spur, err_starve}, 32'h0);
        chk("t6_sid", 32'(starve_id), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
